// File: rtl/xosera_bus_ctrl_pkg.sv
// Shared Xosera bus types and constants: bus pin polarities, register index width
// and the bus sequencer state encoding.
package xv;
  localparam logic cs_ENABLED = 1'b0;
  localparam logic RnW_READ   = 1'b1;
  localparam int   REGNUM_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WRITE,
    READ,
    RD_WAIT,
    HOLD
  } bus_state_t;
endpackage

// File: rtl/xosera_bus_sync.sv
// Flop-chain synchroniser of configurable width and depth, with a per-bit reset
// value so that idle bus levels can be presented while in reset.
module xosera_bus_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/xosera_bus_ctrl.sv
// Host bus sequencer: synchronises the 8-bit bus, pairs byte writes into 16-bit
// register strobes and returns read bytes. Optional BUS_ATOMIC_READ_EN buffers
// the full word on an even-byte read and serves the matching odd byte from it.
module xosera_bus_ctrl
  import xv::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                bus_cs_n_i,
  input  logic                bus_rd_nwr_i,
  input  logic                bus_bytesel_i,
  input  logic [REGNUM_W-1:0] bus_reg_num_i,
  input  logic [7:0]          bus_data_i,
  output logic [7:0]          bus_data_o,
  output logic                reg_wr_o,
  output logic                reg_rd_o,
  output logic [REGNUM_W-1:0] reg_num_o,
  output logic [15:0]         reg_data_o,
  input  logic [15:0]         reg_data_i
);
  localparam int               BUS_W    = 3 + REGNUM_W + 8;
  localparam logic [BUS_W-1:0] BUS_RST  = {1'b1, {(BUS_W-1){1'b0}}};
  localparam logic [1:0]       LAST_CNT = 2'(RD_LATENCY - 1);

  logic [BUS_W-1:0]    bus_s;
  logic                s_cs_n, s_rd_nwr, s_bytesel;
  logic [REGNUM_W-1:0] s_num;
  logic [7:0]          s_data;

  xosera_bus_sync #(
    .WIDTH  (BUS_W),
    .STAGES (SYNC_STAGES),
    .RST_VAL(BUS_RST)
  ) u_sync (
    .clk(clk),
    .rst(reset_i),
    .d_i({bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i}),
    .q_o(bus_s)
  );

  assign {s_cs_n, s_rd_nwr, s_bytesel, s_num, s_data} = bus_s;

  bus_state_t          state_q, state_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                cs_prev_q, cs_prev_d;
  logic                cap_bytesel_q, cap_bytesel_d;
  logic [7:0]          cap_data_q, cap_data_d;
  logic [7:0]          hi_q, hi_d;
  logic                reg_wr_q, reg_wr_d;
  logic                reg_rd_q, reg_rd_d;
  logic [REGNUM_W-1:0] reg_num_q, reg_num_d;
  logic [15:0]         reg_data_q, reg_data_d;
  logic [7:0]          bus_data_q, bus_data_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                access_start;
`ifdef BUS_ATOMIC_READ_EN
  logic                cap_hit_q, cap_hit_d;
  logic [15:0]         rbuf_q, rbuf_d;
  logic                rbuf_valid_q, rbuf_valid_d;
  logic [REGNUM_W-1:0] rbuf_num_q, rbuf_num_d;
`endif

  // The synchroniser shows its reset value until it has flushed, so the previous
  // cs_n sample is held "low" until then; an access needs a real high->low edge.
  assign fill_d       = {fill_q[SYNC_STAGES-2:0], 1'b1};
  assign cs_prev_d    = fill_q[SYNC_STAGES-1] ? s_cs_n : 1'b0;
  assign access_start = cs_prev_q && (s_cs_n == cs_ENABLED);

  always_comb begin
    state_d       = state_q;
    cap_bytesel_d = cap_bytesel_q;
    cap_data_d    = cap_data_q;
    hi_d          = hi_q;
    reg_wr_d      = 1'b0;
    reg_rd_d      = 1'b0;
    reg_num_d     = reg_num_q;
    reg_data_d    = reg_data_q;
    bus_data_d    = bus_data_q;
    cnt_d         = cnt_q;
`ifdef BUS_ATOMIC_READ_EN
    cap_hit_d     = cap_hit_q;
    rbuf_d        = rbuf_q;
    rbuf_valid_d  = rbuf_valid_q;
    rbuf_num_d    = rbuf_num_q;
`endif
    case (state_q)
      IDLE: if (access_start) state_d = SETTLE;
      SETTLE: begin
        if (s_cs_n != cs_ENABLED) begin
          state_d = IDLE;
        end else begin
          reg_num_d     = s_num;
          cap_bytesel_d = s_bytesel;
          cap_data_d    = s_data;
          cnt_d         = 2'd0;
          if (s_rd_nwr == RnW_READ) begin
            state_d  = READ;
            reg_rd_d = 1'b1;
`ifdef BUS_ATOMIC_READ_EN
            cap_hit_d = s_bytesel && rbuf_valid_q && (rbuf_num_q == s_num);
            reg_rd_d  = !cap_hit_d;
`endif
          end else begin
            state_d  = WRITE;
            reg_wr_d = s_bytesel;
            if (s_bytesel) reg_data_d = {hi_q, s_data};
`ifdef BUS_ATOMIC_READ_EN
            rbuf_valid_d = 1'b0;
`endif
          end
        end
      end
      WRITE: begin
        if (!cap_bytesel_q) hi_d = cap_data_q;
        state_d = HOLD;
      end
      READ: begin
        state_d = RD_WAIT;
`ifdef BUS_ATOMIC_READ_EN
        if (cap_hit_q) begin
          bus_data_d = rbuf_q[7:0];
          state_d    = HOLD;
        end
`endif
      end
      RD_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          bus_data_d = cap_bytesel_q ? reg_data_i[7:0] : reg_data_i[15:8];
          state_d    = HOLD;
`ifdef BUS_ATOMIC_READ_EN
          if (!cap_bytesel_q) begin
            rbuf_d       = reg_data_i;
            rbuf_valid_d = 1'b1;
            rbuf_num_d   = reg_num_q;
          end
`endif
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      HOLD: if (s_cs_n != cs_ENABLED) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      fill_q        <= '0;
      cs_prev_q     <= 1'b0;
      cap_bytesel_q <= 1'b0;
      cap_data_q    <= '0;
      hi_q          <= '0;
      reg_wr_q      <= 1'b0;
      reg_rd_q      <= 1'b0;
      reg_num_q     <= '0;
      reg_data_q    <= '0;
      bus_data_q    <= '0;
      cnt_q         <= '0;
`ifdef BUS_ATOMIC_READ_EN
      cap_hit_q     <= 1'b0;
      rbuf_q        <= '0;
      rbuf_valid_q  <= 1'b0;
      rbuf_num_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      cs_prev_q     <= cs_prev_d;
      cap_bytesel_q <= cap_bytesel_d;
      cap_data_q    <= cap_data_d;
      hi_q          <= hi_d;
      reg_wr_q      <= reg_wr_d;
      reg_rd_q      <= reg_rd_d;
      reg_num_q     <= reg_num_d;
      reg_data_q    <= reg_data_d;
      bus_data_q    <= bus_data_d;
      cnt_q         <= cnt_d;
`ifdef BUS_ATOMIC_READ_EN
      cap_hit_q     <= cap_hit_d;
      rbuf_q        <= rbuf_d;
      rbuf_valid_q  <= rbuf_valid_d;
      rbuf_num_q    <= rbuf_num_d;
`endif
    end
  end

  assign bus_data_o = bus_data_q;
  assign reg_wr_o   = reg_wr_q;
  assign reg_rd_o   = reg_rd_q;
  assign reg_num_o  = reg_num_q;
  assign reg_data_o = reg_data_q;
endmodule

// File: tb/tb_xosera_bus_ctrl.sv
// Directed bench for xosera_bus_ctrl: bus accesses with hand-computed strobes,
// read bytes and cycle positions; BUS_ATOMIC_READ_EN selects the atomic-read expectations.
module tb_xosera_bus_ctrl;
  import xv::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i;
  logic [3:0]  bus_reg_num_i;
  logic [7:0]  bus_data_i;
  logic [7:0]  bus_data_o;
  logic        reg_wr_o, reg_rd_o;
  logic [3:0]  reg_num_o;
  logic [15:0] reg_data_o;
  logic [15:0] reg_data_i;

  int total = 0;
  int bad   = 0;

  // observations from the most recent access
  int          wr_cnt, rd_cnt, wr_at, rd_at;
  logic [15:0] wr_data;
  logic [3:0]  wr_num, rd_num;
  logic [7:0]  bd_tr [40];
  logic [7:0]  exp_bd;

  xosera_bus_ctrl #(.SYNC_STAGES(2), .RD_LATENCY(1)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .bus_cs_n_i   (bus_cs_n_i),
    .bus_rd_nwr_i (bus_rd_nwr_i),
    .bus_bytesel_i(bus_bytesel_i),
    .bus_reg_num_i(bus_reg_num_i),
    .bus_data_i   (bus_data_i),
    .bus_data_o   (bus_data_o),
    .reg_wr_o     (reg_wr_o),
    .reg_rd_o     (reg_rd_o),
    .reg_num_o    (reg_num_o),
    .reg_data_o   (reg_data_o),
    .reg_data_i   (reg_data_i)
  );

  always #5 clk = ~clk;

  // register file model: data valid exactly one cycle after a read request
  logic [15:0] mem [16];
  logic        rd_v;
  logic [3:0]  rd_n;
  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rd_v <= 1'b0;
      rd_n <= 4'd0;
    end else begin
      rd_v <= reg_rd_o;
      rd_n <= reg_num_o;
    end
  end
  assign reg_data_i = rd_v ? mem[rd_n] : 16'hDEAD;

  // starts and ends at a falling edge; cycle k = sample #1 after the k-th rising edge
  task automatic access(input logic rd, input logic bsel, input logic [3:0] num,
                        input logic [7:0] dat, input int hold);
    wr_cnt = 0; rd_cnt = 0; wr_at = 0; rd_at = 0;
    wr_data = '0; wr_num = '0; rd_num = '0;
    bus_rd_nwr_i = rd; bus_bytesel_i = bsel; bus_reg_num_i = num; bus_data_i = dat;
    bus_cs_n_i = 1'b0;
    for (int k = 1; k <= hold + 8; k++) begin
      @(posedge clk); #1;
      if (reg_wr_o) begin
        wr_cnt++; if (wr_at == 0) wr_at = k;
        wr_data = reg_data_o; wr_num = reg_num_o;
      end
      if (reg_rd_o) begin
        rd_cnt++; if (rd_at == 0) rd_at = k;
        rd_num = reg_num_o;
      end
      bd_tr[k] = bus_data_o;
      @(negedge clk);
      if (k == hold) bus_cs_n_i = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; bus_cs_n_i = 1'b1; bus_rd_nwr_i = 1'b0; bus_bytesel_i = 1'b0;
    bus_reg_num_i = 4'd0; bus_data_i = 8'd0;
    repeat (3) @(negedge clk);
    total++; if (reg_wr_o !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b exp=0", reg_wr_o); end
    total++; if (reg_rd_o !== 1'b0) begin bad++; $display("FAIL rst_rd got=%b exp=0", reg_rd_o); end
    total++; if (reg_num_o !== 4'd0) begin bad++; $display("FAIL rst_num got=%h exp=0", reg_num_o); end
    total++; if (reg_data_o !== 16'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", reg_data_o); end
    total++; if (bus_data_o !== 8'd0) begin bad++; $display("FAIL rst_bus_data got=%h exp=0", bus_data_o); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=IDLE", dut.state_q); end
    reset_i = 1'b0;
    repeat (4) @(negedge clk);
    exp_bd = 8'h00;
  endtask

  task automatic test_write();
    access(1'b0, 1'b0, 4'd3, 8'hAB, 8);
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL even_wr_cnt got=%0d exp=0", wr_cnt); end
    total++; if (rd_cnt !== 0) begin bad++; $display("FAIL even_rd_cnt got=%0d exp=0", rd_cnt); end
    access(1'b0, 1'b1, 4'd3, 8'hCD, 8);
    total++; if (wr_cnt !== 1) begin bad++; $display("FAIL odd_wr_cnt got=%0d exp=1", wr_cnt); end
    total++; if (wr_at !== 4) begin bad++; $display("FAIL odd_wr_cycle got=%0d exp=4", wr_at); end
    total++; if (wr_num !== 4'd3) begin bad++; $display("FAIL odd_wr_num got=%h exp=3", wr_num); end
    total++; if (wr_data !== 16'hABCD) begin bad++; $display("FAIL odd_wr_data got=%h exp=abcd", wr_data); end
  endtask

  task automatic test_read();
    int exp_rd;
    mem[5] = 16'h1234;
    access(1'b1, 1'b0, 4'd5, 8'h00, 8);
    total++; if (rd_cnt !== 1) begin bad++; $display("FAIL even_rd_cnt got=%0d exp=1", rd_cnt); end
    total++; if (rd_at !== 4) begin bad++; $display("FAIL even_rd_cycle got=%0d exp=4", rd_at); end
    total++; if (rd_num !== 4'd5) begin bad++; $display("FAIL even_rd_num got=%h exp=5", rd_num); end
    total++; if (bd_tr[5] !== exp_bd) begin bad++; $display("FAIL even_rd_early got=%h exp=%h", bd_tr[5], exp_bd); end
    total++; if (bd_tr[6] !== 8'h12) begin bad++; $display("FAIL even_rd_data got=%h exp=12", bd_tr[6]); end
    total++; if (bus_data_o !== 8'h12) begin bad++; $display("FAIL even_rd_hold got=%h exp=12", bus_data_o); end
    exp_bd = 8'h12;
    access(1'b1, 1'b1, 4'd5, 8'h00, 8);
`ifdef BUS_ATOMIC_READ_EN
    exp_rd = 0;
    total++; if (bd_tr[5] !== 8'h34) begin bad++; $display("FAIL odd_rd_data got=%h exp=34", bd_tr[5]); end
`else
    exp_rd = 1;
    total++; if (bd_tr[5] !== exp_bd) begin bad++; $display("FAIL odd_rd_early got=%h exp=%h", bd_tr[5], exp_bd); end
    total++; if (bd_tr[6] !== 8'h34) begin bad++; $display("FAIL odd_rd_data got=%h exp=34", bd_tr[6]); end
`endif
    total++; if (rd_cnt !== exp_rd) begin bad++; $display("FAIL odd_rd_cnt got=%0d exp=%0d", rd_cnt, exp_rd); end
    exp_bd = 8'h34;
  endtask

  task automatic test_abort();
    access(1'b0, 1'b1, 4'd4, 8'h99, 1);
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL abort_wr got=%0d exp=0", wr_cnt); end
    total++; if (rd_cnt !== 0) begin bad++; $display("FAIL abort_rd got=%0d exp=0", rd_cnt); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL abort_state got=%0d exp=IDLE", dut.state_q); end
    access(1'b1, 1'b0, 4'd5, 8'h00, 1);
    total++; if (rd_cnt !== 0) begin bad++; $display("FAIL abort_read_rd got=%0d exp=0", rd_cnt); end
  endtask

  task automatic test_long_hold();
    access(1'b0, 1'b1, 4'd9, 8'h55, 20);
    total++; if (wr_cnt !== 1) begin bad++; $display("FAIL long_wr_cnt got=%0d exp=1", wr_cnt); end
    total++; if (wr_data !== 16'hAB55) begin bad++; $display("FAIL stale_hi_data got=%h exp=ab55", wr_data); end
    total++; if (wr_num !== 4'd9) begin bad++; $display("FAIL long_wr_num got=%h exp=9", wr_num); end
    access(1'b0, 1'b1, 4'd2, 8'h66, 8);
    total++; if (wr_cnt !== 1) begin bad++; $display("FAIL next_wr_cnt got=%0d exp=1", wr_cnt); end
    total++; if (wr_data !== 16'hAB66) begin bad++; $display("FAIL next_wr_data got=%h exp=ab66", wr_data); end
  endtask

  task automatic test_atomic();
    int exp_rd;
    logic [7:0] exp_odd;
    mem[7] = 16'hBEEF;
    access(1'b1, 1'b0, 4'd7, 8'h00, 8);
    total++; if (bus_data_o !== 8'hBE) begin bad++; $display("FAIL atom_even got=%h exp=be", bus_data_o); end
    mem[7] = 16'h0000;
    access(1'b1, 1'b1, 4'd7, 8'h00, 8);
`ifdef BUS_ATOMIC_READ_EN
    exp_rd = 0; exp_odd = 8'hEF;
`else
    exp_rd = 1; exp_odd = 8'h00;
`endif
    total++; if (rd_cnt !== exp_rd) begin bad++; $display("FAIL atom_rd_cnt got=%0d exp=%0d", rd_cnt, exp_rd); end
    total++; if (bus_data_o !== exp_odd) begin bad++; $display("FAIL atom_odd got=%h exp=%h", bus_data_o, exp_odd); end
    // a write invalidates any buffered word
    access(1'b0, 1'b1, 4'd7, 8'h11, 8);
    mem[7] = 16'h4321;
    access(1'b1, 1'b1, 4'd7, 8'h00, 8);
    total++; if (rd_cnt !== 1) begin bad++; $display("FAIL atom_inval_rd got=%0d exp=1", rd_cnt); end
    total++; if (bus_data_o !== 8'h21) begin bad++; $display("FAIL atom_inval_data got=%h exp=21", bus_data_o); end
    exp_bd = 8'h21;
  endtask

  task automatic test_reset_mid();
    int cnt;
    bus_rd_nwr_i = 1'b1; bus_bytesel_i = 1'b1; bus_reg_num_i = 4'd5; bus_data_i = 8'h00;
    bus_cs_n_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (dut.state_q !== RD_WAIT) begin bad++; $display("FAIL mid_state got=%0d exp=RD_WAIT", dut.state_q); end
    reset_i = 1'b1;
    #1;
    total++; if (bus_data_o !== 8'h00) begin bad++; $display("FAIL mid_rst_bus_data got=%h exp=0", bus_data_o); end
    total++; if (reg_data_o !== 16'h0000) begin bad++; $display("FAIL mid_rst_data got=%h exp=0", reg_data_o); end
    total++; if (reg_num_o !== 4'd0) begin bad++; $display("FAIL mid_rst_num got=%h exp=0", reg_num_o); end
    total++; if (reg_rd_o !== 1'b0 || reg_wr_o !== 1'b0) begin
      bad++; $display("FAIL mid_rst_strobes got=%b%b exp=00", reg_rd_o, reg_wr_o);
    end
    @(negedge clk);
    reset_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (reg_rd_o || reg_wr_o) cnt++;
      @(negedge clk);
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL post_rst_low_strobes got=%0d exp=0", cnt); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL post_rst_state got=%0d exp=IDLE", dut.state_q); end
    bus_cs_n_i = 1'b1;
    repeat (5) @(negedge clk);
    access(1'b1, 1'b0, 4'd5, 8'h00, 8);
    total++; if (rd_cnt !== 1) begin bad++; $display("FAIL post_rst_rd_cnt got=%0d exp=1", rd_cnt); end
    total++; if (bus_data_o !== 8'h12) begin bad++; $display("FAIL post_rst_rd_data got=%h exp=12", bus_data_o); end
    // hi latch was cleared by reset
    access(1'b0, 1'b1, 4'd1, 8'h77, 8);
    total++; if (wr_data !== 16'h0077) begin bad++; $display("FAIL post_rst_hi got=%h exp=0077", wr_data); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    reset_i = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_long_hold();
    test_atomic();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
